// File: rtl/serial_receive_if.sv
// serial_receive_if: link input, consumer handshake and status outputs of the serial receiver
interface serial_receive_if #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int ERR_CNT_W  = 8
);
  logic                          connection_status;
  logic                          rxd;
  logic [DATA_W-1:0]             word_out;
  logic                          word_valid;
  logic                          word_ready;
  logic                          frame_err;
  logic                          overrun;
  logic [ERR_CNT_W-1:0]          err_count;
  logic [$clog2(FIFO_DEPTH):0]   fifo_level;
  modport master (
    input  connection_status, rxd, word_ready,
    output word_out, word_valid, frame_err, overrun, err_count, fifo_level
  );
  modport slave (
    output connection_status, rxd, word_ready,
    input  word_out, word_valid, frame_err, overrun, err_count, fifo_level
  );
endinterface

// File: rtl/serial_receive.sv
// serial_receive: counter-framed serial deserialiser with separator check, output FIFO and error counter
module serial_receive #(
  parameter int DATA_W       = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int LINK_LATENCY = 1,
  parameter int ERR_CNT_W    = 8
) (
  input logic             clk,
  input logic             rst,
  serial_receive_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(DATA_W + LINK_LATENCY + 1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ALIGN = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] SEP   = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0]    sh_q, sh_d;
  logic [DATA_W-1:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]        level_q;
  logic [ERR_CNT_W-1:0] err_q;
  logic                 ferr_q, ovr_q;
  logic                 push, ferr, pop, full, wr;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    push    = 1'b0;
    ferr    = 1'b0;
    if (!bus.connection_status) state_d = IDLE;
    else case (state_q)
      IDLE: begin
        cnt_d   = '0;
        state_d = LINK_LATENCY > 1 ? ALIGN : DATA;
        // Zero latency: this edge already carries the MSB
        if (LINK_LATENCY == 0) begin
          sh_d  = {sh_q[DATA_W-2:0], bus.rxd};
          cnt_d = CW'(1);
        end
      end
      ALIGN: begin
        cnt_d   = cnt_q == CW'(LINK_LATENCY - 2) ? '0 : cnt_q + CW'(1);
        state_d = cnt_q == CW'(LINK_LATENCY - 2) ? DATA : ALIGN;
      end
      DATA: begin
        sh_d    = {sh_q[DATA_W-2:0], bus.rxd};
        cnt_d   = cnt_q == CW'(DATA_W - 1) ? '0 : cnt_q + CW'(1);
        state_d = cnt_q == CW'(DATA_W - 1) ? SEP : DATA;
      end
      SEP: begin
        push    = !bus.rxd;
        ferr    = bus.rxd;
        cnt_d   = '0;
        state_d = DATA;
      end
    endcase
  end

  // A push into a full FIFO still lands when the head is popped on the same edge
  assign pop  = (level_q != '0) && bus.word_ready;
  assign full = level_q == LW'(FIFO_DEPTH);
  assign wr   = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sh_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      err_q    <= '0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      wr_ptr_q <= wr_ptr_q + AW'(wr);
      rd_ptr_q <= rd_ptr_q + AW'(pop);
      level_q  <= level_q + LW'(wr) - LW'(pop);
      err_q    <= (ferr && !(&err_q)) ? err_q + ERR_CNT_W'(1) : err_q;
      ferr_q   <= ferr;
      ovr_q    <= push && full && !pop;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr) mem_q[wr_ptr_q] <= sh_q;
  end

  assign bus.word_out   = level_q != '0 ? mem_q[rd_ptr_q] : '0;
  assign bus.word_valid = level_q != '0;
  assign bus.frame_err  = ferr_q;
  assign bus.overrun    = ovr_q;
  assign bus.err_count  = err_q;
  assign bus.fifo_level = level_q;
endmodule

// File: tb/tb_serial_receive.sv
// tb_serial_receive: scenario tasks for serial_receive with a word scoreboard checked at the consumer
module tb_serial_receive;
  logic clk = 1'b0;
  logic rst;
  int errors = 0;
  int checks = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic [7:0] q [$];
  logic [7:0] exp_w;

  always #5 clk = ~clk;

  serial_receive_if bus ();
  serial_receive dut (.clk(clk), .rst(rst), .bus(bus));

  always @(negedge clk) begin
    if (bus.frame_err === 1'b1) fe_cnt++;
    if (bus.overrun === 1'b1) ov_cnt++;
    if (rst === 1'b0 && bus.word_valid === 1'b1 && bus.word_ready === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: got unexpected word %h, queue empty", bus.word_out);
      end else begin
        exp_w = q.pop_front();
        if (bus.word_out !== exp_w) begin
          errors++;
          $display("FAIL scoreboard: got %h expected %h", bus.word_out, exp_w);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic connect();
    bus.connection_status = 1'b1;
    tick();
  endtask

  task automatic disconnect();
    bus.connection_status = 1'b0;
    bus.rxd = 1'b1;
    tick();
  endtask

  task automatic send_bits(input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      bus.rxd = d[7-i];
      tick();
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic sep, input logic keep);
    send_bits(d, 8);
    if (!sep && keep) q.push_back(d);
    bus.rxd = sep;
    tick();
    bus.rxd = 1'b1;
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while ((q.size() != 0 || bus.word_valid !== 1'b0) && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (q.size() != 0 || bus.word_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s drain: got %0d words pending valid=%b, required 0 and 0", name, q.size(), bus.word_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.connection_status = 1'b0;
    bus.rxd = 1'b1;
    bus.word_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({bus.word_valid, bus.word_out, bus.fifo_level, bus.err_count, bus.frame_err, bus.overrun} !== '0) begin
      errors++;
      $display("FAIL reset: got valid=%b out=%h lvl=%0d err=%0d fe=%b ov=%b, required all 0",
               bus.word_valid, bus.word_out, bus.fifo_level, bus.err_count, bus.frame_err, bus.overrun);
    end
  endtask

  task automatic test_single();
    bus.word_ready = 1'b1;
    connect();
    send_frame(8'hA5, 1'b0, 1'b1);
    checks++;
    if (bus.word_valid !== 1'b1 || bus.word_out !== 8'hA5) begin
      errors++;
      $display("FAIL single_out: got valid=%b out=%h, required 1 a5", bus.word_valid, bus.word_out);
    end
    disconnect();
    checks++;
    if (bus.word_valid !== 1'b0 || bus.err_count !== 8'd0) begin
      errors++;
      $display("FAIL single_after: got valid=%b err=%0d, required 0 0", bus.word_valid, bus.err_count);
    end
    wait_empty("single");
  endtask

  task automatic test_frame_err();
    int fe0 = fe_cnt;
    bus.word_ready = 1'b1;
    connect();
    send_frame(8'h3C, 1'b1, 1'b0);
    checks++;
    if (bus.frame_err !== 1'b1 || bus.err_count !== 8'd1) begin
      errors++;
      $display("FAIL frame_err_pulse: got fe=%b err=%0d, required 1 1", bus.frame_err, bus.err_count);
    end
    send_frame(8'h81, 1'b0, 1'b1);
    checks++;
    if (bus.frame_err !== 1'b0) begin
      errors++;
      $display("FAIL frame_err_clear: got %b, required 0", bus.frame_err);
    end
    disconnect();
    wait_empty("frame_err");
    checks++;
    if (fe_cnt - fe0 != 1) begin
      errors++;
      $display("FAIL frame_err_count: got %0d pulses, required 1", fe_cnt - fe0);
    end
  endtask

  task automatic test_overrun();
    int ov0 = ov_cnt;
    bus.word_ready = 1'b0;
    connect();
    for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b0, k < 5);
    checks++;
    if (bus.overrun !== 1'b1 || bus.fifo_level !== 3'd4) begin
      errors++;
      $display("FAIL overrun_pulse: got ov=%b lvl=%0d, required 1 4", bus.overrun, bus.fifo_level);
    end
    disconnect();
    checks++;
    if (bus.overrun !== 1'b0 || bus.fifo_level !== 3'd4) begin
      errors++;
      $display("FAIL overrun_hold: got ov=%b lvl=%0d, required 0 4", bus.overrun, bus.fifo_level);
    end
    bus.word_ready = 1'b1;
    wait_empty("overrun");
    checks++;
    if (ov_cnt - ov0 != 1) begin
      errors++;
      $display("FAIL overrun_count: got %0d pulses, required 1", ov_cnt - ov0);
    end
  endtask

  task automatic test_disconnect();
    int fe0 = fe_cnt;
    bus.word_ready = 1'b1;
    connect();
    send_bits(8'hF0, 4);
    disconnect();
    connect();
    send_frame(8'h5A, 1'b0, 1'b1);
    disconnect();
    wait_empty("disconnect");
    checks++;
    if (fe_cnt - fe0 != 0 || bus.err_count !== 8'd1) begin
      errors++;
      $display("FAIL disconnect_err: got %0d pulses err=%0d, required 0 1", fe_cnt - fe0, bus.err_count);
    end
  endtask

  task automatic test_mid_reset();
    bus.word_ready = 1'b0;
    connect();
    send_frame(8'h12, 1'b0, 1'b1);
    send_frame(8'h34, 1'b0, 1'b1);
    send_bits(8'hC3, 3);
    rst = 1'b1;
    bus.connection_status = 1'b0;
    tick();
    rst = 1'b0;
    q.delete();
    checks++;
    if ({bus.word_valid, bus.word_out, bus.fifo_level, bus.err_count, bus.frame_err, bus.overrun} !== '0) begin
      errors++;
      $display("FAIL mid_reset: got valid=%b out=%h lvl=%0d err=%0d fe=%b ov=%b, required all 0",
               bus.word_valid, bus.word_out, bus.fifo_level, bus.err_count, bus.frame_err, bus.overrun);
    end
    bus.word_ready = 1'b1;
    connect();
    send_frame(8'h96, 1'b0, 1'b1);
    disconnect();
    wait_empty("mid_reset");
  endtask

  task automatic test_full_push_pop();
    bus.word_ready = 1'b0;
    connect();
    send_frame(8'h11, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1);
    send_frame(8'h33, 1'b0, 1'b1);
    send_frame(8'h44, 1'b0, 1'b1);
    send_bits(8'h77, 8);
    q.push_back(8'h77);
    bus.word_ready = 1'b1;
    bus.rxd = 1'b0;
    tick();
    checks++;
    if (bus.overrun !== 1'b0 || bus.fifo_level !== 3'd4) begin
      errors++;
      $display("FAIL full_push_pop: got ov=%b lvl=%0d, required 0 4", bus.overrun, bus.fifo_level);
    end
    disconnect();
    wait_empty("full_push_pop");
  endtask

  task automatic test_saturate();
    int fe0 = fe_cnt;
    bus.word_ready = 1'b1;
    connect();
    for (int i = 0; i < 300; i++) begin
      send_frame(8'h00, 1'b1, 1'b0);
      if (i == 253) begin
        checks++;
        if (bus.err_count !== 8'hFE) begin
          errors++;
          $display("FAIL saturate_254: got %h, required fe", bus.err_count);
        end
      end
      if (i == 254) begin
        checks++;
        if (bus.err_count !== 8'hFF) begin
          errors++;
          $display("FAIL saturate_255: got %h, required ff", bus.err_count);
        end
      end
    end
    disconnect();
    checks++;
    if (bus.err_count !== 8'hFF || fe_cnt - fe0 != 300) begin
      errors++;
      $display("FAIL saturate_end: got err=%h pulses=%0d, required ff 300", bus.err_count, fe_cnt - fe0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_frame_err();
    test_overrun();
    test_disconnect();
    test_mid_reset();
    test_full_push_pop();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
